// File: rtl/call_dispatcher.sv
// ============================================================================
//  Module   : call_dispatcher
//  Brief    : Call-button front end for the elevator fsm: sync/debounce,
//             pending-call register, nearest-floor dispatch. Optional
//             debounce enabled by CALL_DISPATCHER_DEBOUNCE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module call_dispatcher #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic [1:0] floor,
    input  logic [1:0] dir,
    input  logic       busy,
    output logic [5:0] req,
    output logic [5:0] pending,
    output logic [1:0] target,
    output logic       dispatching
);

    localparam int c_HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [5:0]        r_sync1, r_sync2, r_cond_d;
    logic [5:0]        w_cond, w_press;
    logic [c_HW-1:0]   r_hold, w_hold_nxt;
    logic [5:0]        w_req_nxt, w_pending_nxt;
    logic [1:0]        w_target_nxt;
    logic              w_disp_nxt, w_do_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cond_d <= '0;
        end else begin
            r_sync1  <= btn;
            r_sync2  <= r_sync1;
            r_cond_d <= w_cond;
        end
    end

`ifdef CALL_DISPATCHER_DEBOUNCE_EN
    localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 6; i++) begin : g_debounce
        logic [c_CW-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst || !r_sync2[i])
                r_cnt <= '0;
            else if (r_cnt != c_CW'(DEBOUNCE_CYCLES))
                r_cnt <= r_cnt + c_CW'(1);
        end
        assign w_cond[i] = (r_cnt == c_CW'(DEBOUNCE_CYCLES));
    end
`else
    if (1) begin : g_no_debounce
        assign w_cond = r_sync2;
    end
`endif

    assign w_press = w_cond & ~r_cond_d;

    // Nearest-floor selection; ties go up only when the car is heading up
    logic [2:0] w_has;
    logic       w_found;
    logic [1:0] w_best, w_best_dist, w_dist;
    logic [2:0] w_sel_idx;
    logic [5:0] w_sel_req;

    always_comb begin
        w_has       = pending[2:0] | pending[5:3];
        w_found     = 1'b0;
        w_best      = 2'd0;
        w_best_dist = 2'd0;
        w_dist      = 2'd0;
        for (int f = 0; f < 3; f++) begin
            w_dist = (floor > 2'(f)) ? (floor - 2'(f)) : (2'(f) - floor);
            if (w_has[f] && (!w_found || (w_dist < w_best_dist) ||
                             ((w_dist == w_best_dist) && (dir == 2'b01)))) begin
                w_found     = 1'b1;
                w_best      = 2'(f);
                w_best_dist = w_dist;
            end
        end
        w_sel_idx = pending[{1'b0, w_best}] ? {1'b0, w_best} : ({1'b0, w_best} + 3'd3);
        w_sel_req = 6'b0;
        w_sel_req[w_sel_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = req;
        w_target_nxt = target;
        w_disp_nxt   = dispatching;
        w_hold_nxt   = r_hold;
        w_do_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                if ((pending != 6'b0) && !busy) begin
                    w_req_nxt    = w_sel_req;
                    w_target_nxt = w_best;
                    w_disp_nxt   = 1'b1;
                    w_hold_nxt   = '0;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (busy) begin
                    w_req_nxt   = 6'b0;
                    w_state_nxt = WAIT;
                end else if (r_hold == c_HW'(HOLD_CYCLES - 1)) begin
                    w_req_nxt   = 6'b0;
                    w_disp_nxt  = 1'b0;
                    w_do_clr    = (floor == target);
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold + c_HW'(1);
                end
            end
            WAIT: begin
                if (!busy) begin
                    w_disp_nxt  = 1'b0;
                    w_do_clr    = (floor == target);
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_req_nxt   = 6'b0;
                w_disp_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Clear beats a simultaneous press for the same floor
    logic [5:0] w_clr_mask;
    always_comb begin
        w_clr_mask = 6'b0;
        if (w_do_clr) begin
            w_clr_mask[{1'b0, target}]          = 1'b1;
            w_clr_mask[{1'b0, target} + 3'd3]   = 1'b1;
        end
        w_pending_nxt = (pending | w_press) & ~w_clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            req         <= '0;
            pending     <= '0;
            target      <= '0;
            dispatching <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            req         <= w_req_nxt;
            pending     <= w_pending_nxt;
            target      <= w_target_nxt;
            dispatching <= w_disp_nxt;
        end
    end

endmodule

`default_nettype wire
